// File: rtl/dac_sample_feeder.sv
// dac_sample_feeder: FIFO-buffered, fixed-rate sample launcher for the SPI DAC transmitter.
// Optional build macro DAC_FEED_HOLD_EN: on underrun, relaunch the last sample.
module dac_sample_feeder #(
  parameter int DEPTH    = 16,
  parameter int RATE_DIV = 2000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     wr_en,
  input  logic [11:0]              wr_data,
  input  logic                     cs,
  output logic                     newd,
  output logic [11:0]              data_in,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     underrun,
  output logic                     late
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(RATE_DIV);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    BUSY
  } state_t;

  state_t          state;
  logic [TW-1:0]   cnt;
  logic            tick;
  logic            cs_m;
  logic            cs_s;
  logic [11:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   level_nxt;
  logic            push;
  logic            pop;

  assign tick = enable && (cnt == TW'(RATE_DIV - 1));
  assign pop  = tick && (state == IDLE) && !empty;
  assign push = wr_en && (!full || pop);

  // Sample-period timer; held at zero while disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (!enable || tick)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  // cs comes from the transmitter's derived clock domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_m <= 1'b1;
      cs_s <= 1'b1;
    end else begin
      cs_m <= cs;
      cs_s <= cs_m;
    end
  end

  // Next occupancy from this cycle's push/pop
  always_comb begin
    level_nxt = level;
    unique case ({push, pop})
      2'b10:   level_nxt = level + 1'b1;
      2'b01:   level_nxt = level - 1'b1;
      default: level_nxt = level;
    endcase
  end

  // Sample storage; contents need no reset
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= wr_data;
  end

  // FIFO pointers, registered flags and drop detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      level    <= level_nxt;
      full     <= (level_nxt == LW'(DEPTH));
      empty    <= (level_nxt == '0);
      overflow <= wr_en && full && !pop;
    end
  end

`ifdef DAC_FEED_HOLD_EN
  logic launched;

  // Remembers whether data_in holds a real sample worth refreshing
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      launched <= 1'b0;
    else if (pop)
      launched <= 1'b1;
  end
`endif

  // Launch/acknowledge sequencer with period-fault pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      newd     <= 1'b0;
      data_in  <= '0;
      underrun <= 1'b0;
      late     <= 1'b0;
    end else begin
      underrun <= tick && (state == IDLE) && empty;
      late     <= tick && (state != IDLE);
      unique case (state)
        IDLE: begin
          if (pop) begin
            data_in <= mem[rd_ptr];
            newd    <= 1'b1;
            state   <= REQ;
          end
`ifdef DAC_FEED_HOLD_EN
          else if (tick && launched) begin
            newd  <= 1'b1;
            state <= REQ;
          end
`endif
        end
        REQ: begin
          if (!cs_s) begin
            newd  <= 1'b0;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (cs_s)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_sample_feeder.sv
// tb_dac_sample_feeder: queue-based reference model with per-cycle compare,
// stub cs responder and directed scenarios with literal expectations.
module tb_dac_sample_feeder;

  localparam int DEPTH = 4;
  localparam int RD    = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable = 1'b0;
  logic        wr_en = 1'b0;
  logic [11:0] wr_data = '0;
  logic        cs = 1'b1;
  logic        newd;
  logic [11:0] data_in;
  logic        full;
  logic        empty;
  logic [2:0]  level;
  logic        overflow;
  logic        underrun;
  logic        late;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int hold = 4;
  int n_ovf, n_und, n_late;
  int lt[$];
  logic [11:0] ld[$];
  logic pn = 1'b0;

  dac_sample_feeder #(.DEPTH(DEPTH), .RATE_DIV(RD)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .wr_en(wr_en), .wr_data(wr_data), .cs(cs),
    .newd(newd), .data_in(data_in),
    .full(full), .empty(empty), .level(level),
    .overflow(overflow), .underrun(underrun), .late(late)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Reference model: a sample queue, a period counter and three phases
  logic [11:0] mq[$];
  int          m_cnt;
  int          m_st;
  logic        m_csm, m_css, m_tick, m_pop, m_launched;
  logic        e_newd, e_ovf, e_und, e_late;
  logic [11:0] e_data;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_cnt = 0; m_st = 0; m_csm = 1; m_css = 1;
      e_newd = 0; e_data = 0; e_ovf = 0; e_und = 0; e_late = 0;
      m_launched = 0;
    end else begin
      m_tick = enable && (m_cnt == RD - 1);
      m_cnt  = (!enable || m_tick) ? 0 : m_cnt + 1;
      m_pop  = m_tick && m_st == 0 && mq.size() != 0;
      e_ovf  = wr_en && mq.size() == DEPTH && !m_pop;
      e_und  = m_tick && m_st == 0 && mq.size() == 0;
      e_late = m_tick && m_st != 0;
      if (m_st == 0) begin
        if (m_pop) begin
          e_data = mq.pop_front();
          e_newd = 1; m_st = 1; m_launched = 1;
        end
`ifdef DAC_FEED_HOLD_EN
        else if (e_und && m_launched) begin
          e_newd = 1; m_st = 1;
        end
`endif
      end else if (m_st == 1) begin
        if (!m_css) begin
          e_newd = 0; m_st = 2;
        end
      end else if (m_css) begin
        m_st = 0;
      end
      if (wr_en && !e_ovf) mq.push_back(wr_data);
      m_css = m_csm;
      m_csm = cs;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (!rst) begin
      chk("newd", newd, e_newd);
      chk("data_in", data_in, e_data);
      chk("level", level, mq.size());
      chk("empty", empty, mq.size() == 0);
      chk("full", full, mq.size() == DEPTH);
      chk("overflow", overflow, e_ovf);
      chk("underrun", underrun, e_und);
      chk("late", late, e_late);
    end
  end

  // Event log: launch times/data and pulse counts
  always @(negedge clk) begin
    if (newd && !pn) begin
      lt.push_back(cyc);
      ld.push_back(data_in);
    end
    pn = newd;
    if (overflow) n_ovf++;
    if (underrun) n_und++;
    if (late) n_late++;
  end

  // Stub transmitter: acknowledges a request, holds cs low for 'hold' cycles
  initial begin
    forever begin
      @(negedge clk);
      if (newd && !rst) begin
        repeat (2) @(posedge clk);
        #1 cs = 1'b0;
        repeat (hold) @(posedge clk);
        #1 cs = 1'b1;
      end
    end
  end

  task automatic clr();
    @(posedge clk);
    lt.delete(); ld.delete();
    n_ovf = 0; n_und = 0; n_late = 0;
  endtask

  task automatic wr(input logic [11:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    clr();
    @(negedge clk);
    chk("rst_newd", newd, 0);
    chk("rst_empty", empty, 1);
    chk("rst_level", level, 0);
    run(39);
    chk("idle_underruns", n_ud_get(), 2);

    // ordered stream
    @(negedge clk); enable = 1'b0;
    run(2);
    wr(12'h123); wr(12'hABC); wr(12'hFFF);
    @(negedge clk);
    chk("stream_level", level, 3);
    clr();
    @(negedge clk); enable = 1'b1;
    run(3 * RD + 20);
    chk("stream_cnt_ok", lt.size() >= 3, 1);
    if (lt.size() >= 3) begin
      chk("stream_d0", ld[0], 12'h123);
      chk("stream_d1", ld[1], 12'hABC);
      chk("stream_d2", ld[2], 12'hFFF);
      chk("stream_gap1", lt[1] - lt[0], RD);
      chk("stream_gap2", lt[2] - lt[1], RD);
    end
    chk("stream_level_end", level, 0);
    @(negedge clk); enable = 1'b0;
    run(30);

    // full / overflow, then push+pop on the tick cycle
    clr();
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_data = 12'(i);
    end
    @(negedge clk); wr_en = 1'b0;
    run(2);
    @(negedge clk);
    chk("ovf_count", n_ovf, 1);
    chk("ovf_level", level, 4);
    chk("ovf_full", full, 1);
    enable = 1'b1;
    run(15);
    @(negedge clk); wr_en = 1'b1; wr_data = 12'h006;
    @(negedge clk); wr_en = 1'b0;
    chk("pp_level", level, 4);
    chk("pp_overflow", overflow, 0);
    run(5 * RD + 10);
    chk("pp_cnt_ok", ld.size() >= 5, 1);
    if (ld.size() >= 5) begin
      chk("pp_d0", ld[0], 12'h001);
      chk("pp_d3", ld[3], 12'h004);
      chk("pp_d4", ld[4], 12'h006);
    end
    @(negedge clk); enable = 1'b0;
    run(30);

    // late tick: long cs low
    hold = 20;
    wr(12'h777); wr(12'h778);
    clr();
    @(negedge clk); enable = 1'b1;
    run(4 * RD + 30);
    chk("late_seen", n_late >= 1, 1);
    chk("late_cnt_ok", lt.size() >= 2, 1);
    if (lt.size() >= 2) begin
      chk("late_gap", lt[1] - lt[0], 2 * RD);
      chk("late_d1", ld[1], 12'h778);
    end
    @(negedge clk); enable = 1'b0;
    run(40);

    // underrun hold behaviour
    hold = 4;
    do_reset();
    wr(12'h5A5);
    clr();
    @(negedge clk); enable = 1'b1;
    run(4 * RD + 8);
    chk("hold_underruns", n_und, 3);
`ifdef DAC_FEED_HOLD_EN
    chk("hold_launches", lt.size(), 4);
    if (lt.size() >= 4) chk("hold_d3", ld[3], 12'h5A5);
`else
    chk("hold_launches", lt.size(), 1);
`endif
    if (lt.size() >= 1) chk("hold_d0", ld[0], 12'h5A5);
    @(negedge clk); enable = 1'b0;
    run(20);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  function automatic int n_ud_get();
    return n_und;
  endfunction

endmodule

// File: doc/dac_sample_feeder.md
# dac_sample_feeder

Upstream stage of the SPI DAC transmitter. Buffers 12-bit DAC samples from the system side in a FIFO and launches one transfer per sample period. Drives the transmitter's `newd`/`data_in` and uses its `cs` as the busy/acknowledge return. Gives the DAC a fixed, programmable update rate independent of producer burstiness.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `RATE_DIV`, 2000: `clk` cycles per sample period.
  - Must exceed one full transmitter transfer, about 1400 `clk` at the transmitter's divide-by-51 `sclk`.

Ports (clock and reset first):
- `clk` in 1: single system clock; all logic on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `enable` in 1: run the sample-period timer.
- `wr_en` in 1: push `wr_data` this cycle.
- `wr_data` in 12: sample to enqueue.
- `cs` in 1: chip select returned from the transmitter; low means a transfer is in progress.
- `newd` out 1: transfer request to the transmitter.
- `data_in` out 12: sample presented to the transmitter.
- `full` out 1: FIFO holds `DEPTH` entries.
- `empty` out 1: FIFO holds 0 entries.
- `level` out $clog2(DEPTH)+1: current occupancy.
- `overflow` out 1: one-cycle pulse when a write is dropped.
- `underrun` out 1: one-cycle pulse on a period tick with the FIFO empty.
- `late` out 1: one-cycle pulse on a period tick while a transfer is still outstanding.

## Operation
- Reset values:
  - `newd`=0, `data_in`=0, `level`=0, `empty`=1, `full`=0.
  - `overflow`, `underrun`, `late` = 0.
  - Timer = 0, state = IDLE, `cs` synchroniser = 1.
- `cs` passes through a 2-flop synchroniser, giving `cs_s`. The transmitter clocks `cs` on a derived clock, so it is treated as asynchronous.
- Timer:
  - While `enable`=1, counts 0..RATE_DIV-1 and wraps.
  - `tick` asserts for one cycle when the count equals RATE_DIV-1.
  - `enable`=0 holds the timer at 0 and stops new ticks. A transfer already in flight runs to completion.
- FIFO:
  - Circular buffer with pointers wrapping modulo `DEPTH`.
  - A push happens when `wr_en`=1 and (`full`=0, or a pop occurs in the same cycle).
  - If `wr_en`=1 while full with no pop, the write is dropped and `overflow` pulses.
  - A pop uses only start-of-cycle occupancy. There is no write-to-read bypass: a write into an empty FIFO is not poppable until the next cycle.
  - `level` is +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
- State machine:
  - **IDLE**
    - On `tick` with `level`>0: pop, load `data_in` with the head entry, set `newd`=1, go to REQ.
    - On `tick` with `level`=0: pulse `underrun`; behaviour per Configuration.
  - **REQ**
    - Hold `newd`=1 and `data_in` stable until `cs_s`=0, then clear `newd` and go to BUSY.
  - **BUSY**
    - Wait for `cs_s`=1, then go to IDLE.
  - A `tick` in REQ or BUSY pulses `late` and is discarded; it is not queued.
- `data_in` keeps the last launched sample between transfers.

## Timing
- Launch latency:
  - `newd` and `data_in` are registered and valid the cycle after `tick`.
  - The FIFO pop happens in the `tick` cycle.
- Acknowledge latency: `newd` falls 3 cycles after `cs` falls (2 synchroniser cycles plus 1 register cycle).
- Return to IDLE happens 3 cycles after `cs` rises.
- Flag timing:
  - `full`, `empty` and `level` are registered and reflect push/pop on the next cycle.
  - `overflow`, `underrun` and `late` are registered, one cycle after the causing event.
- Reset mid-transfer forces IDLE and `newd`=0 immediately. FIFO contents are discarded. The transmitter recovers on its own reset.
- Minimum legal RATE_DIV is 4. The bench uses a stub `cs` responder for small values.

## Configuration
- `DAC_FEED_HOLD_EN` defined:
  - On an underrun tick, if at least one sample has launched since reset, relaunch the current `data_in` (`newd`=1, go to REQ). The DAC keeps refreshing its last value.
  - `underrun` still pulses.
  - If no sample has launched since reset, no launch occurs.
- Not defined: an underrun tick causes no launch, and the state stays IDLE.

## Test plan
- Reset then idle:
  - `rst` pulse with `enable`=1 and no writes → `newd`=0, `empty`=1, `level`=0.
  - `underrun` pulses every RATE_DIV cycles.
- Ordered stream:
  - Write 0x123, 0xABC, 0xFFF; RATE_DIV=2000; real transmitter attached.
  - `data_in` shows 0x123 then 0xABC then 0xFFF, each with one `newd` request.
  - Launches are exactly 2000 cycles apart; `level` ends at 0.
- Full/overflow:
  - DEPTH=4; write 5 samples back-to-back with `enable`=0.
  - `full`=1 after 4, `overflow` pulses once, `level`=4.
  - After enabling, only the first 4 samples are launched.
- Simultaneous push/pop:
  - FIFO full, `wr_en`=1 on the tick cycle → write accepted, `level` stays 4, no `overflow`.
- Late tick:
  - RATE_DIV=8 with a stub holding `cs` low for 20 cycles → `late` pulses.
  - No second `newd` until `cs_s` returns high.
- Underrun hold:
  - Launch 0x5A5, then leave the FIFO empty.
  - With `DAC_FEED_HOLD_EN`: 0x5A5 is relaunched each period.
  - Without it: no further `newd`. `underrun` pulses in both builds.
